// File: rtl/sqrt_step_controller_if.sv
// rtl/sqrt_step_controller_if.sv - start/done handshake and datapath control bundle of the sqrt step controller
interface sqrt_step_controller_if #(
    parameter int ITER_W = 9
);
    logic              start;
    logic              le;
    logic              op_load;
    logic              reg_init;
    logic              step_en;
    logic              res_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter_count;

    // master: the controller; slave: requester plus datapath
    modport master (
        input  start, le,
        output op_load, reg_init, step_en, res_en, busy, done, err, iter_count
    );

    modport slave (
        output start, le,
        input  op_load, reg_init, step_en, res_en, busy, done, err, iter_count
    );
endinterface

// File: rtl/sqrt_step_controller.sv
// rtl/sqrt_step_controller.sv - Moore sequencer for the iterative square-root datapath
// Optional iteration watchdog (FAULT state, err flag) enabled by defining SQRT_CTRL_WATCHDOG_EN.
module sqrt_step_controller #(
    parameter int ITER_W   = 9,
    parameter int MAX_ITER = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    sqrt_step_controller_if.master bus
);
    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INIT, S_CHECK, S_STEP, S_FINISH, S_DONE, S_FAULT
    } state_t;

    state_t            state, next_state;
    logic              op_load_q, reg_init_q, step_en_q, res_en_q, busy_q, done_q, err_q;
    logic              op_load_d, reg_init_d, step_en_d, res_en_d, busy_d, done_d, err_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    // Outputs are registered copies of the next-state decode, so they change
    // together with the state and carry no combinational path from start/le.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            op_load_q  <= 1'b0;
            reg_init_q <= 1'b0;
            step_en_q  <= 1'b0;
            res_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            iter_q     <= '0;
        end else begin
            state      <= next_state;
            op_load_q  <= op_load_d;
            reg_init_q <= reg_init_d;
            step_en_q  <= step_en_d;
            res_en_q   <= res_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            iter_q     <= iter_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (bus.start) next_state = S_LOAD;
            S_LOAD:   next_state = S_INIT;
            S_INIT:   next_state = S_CHECK;
            S_CHECK: begin
                if (!bus.le)
                    next_state = S_FINISH;
`ifdef SQRT_CTRL_WATCHDOG_EN
                else if (iter_q == MAX_CNT)
                    next_state = S_FAULT;
`endif
                else
                    next_state = S_STEP;
            end
            S_STEP:   next_state = S_CHECK;
            S_FINISH: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            S_FAULT:  next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        op_load_d  = (next_state == S_LOAD);
        reg_init_d = (next_state == S_INIT);
        step_en_d  = (next_state == S_STEP);
        res_en_d   = (next_state == S_FINISH);
        busy_d     = (next_state != S_IDLE);
        done_d     = (next_state == S_DONE) || (next_state == S_FAULT);
`ifdef SQRT_CTRL_WATCHDOG_EN
        err_d = err_q;
        if (next_state == S_LOAD)
            err_d = 1'b0;
        else if (next_state == S_FAULT)
            err_d = 1'b1;
`else
        err_d = 1'b0;
`endif
        // Counts completed STEP cycles, saturating so a stuck compare cannot wrap it
        iter_d = iter_q;
        if (next_state == S_LOAD)
            iter_d = '0;
        else if (state == S_STEP && iter_q != MAX_CNT)
            iter_d = iter_q + 1'b1;
    end

    assign bus.op_load    = op_load_q;
    assign bus.reg_init   = reg_init_q;
    assign bus.step_en    = step_en_q;
    assign bus.res_en     = res_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_sqrt_step_controller.sv
// tb/tb_sqrt_step_controller.sv - randomized self-checking bench for sqrt_step_controller with a behavioural datapath
module tb_sqrt_step_controller;
    localparam int ITER_W   = 9;
    localparam int MAX_ITER = 256;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sqrt_step_controller_if #(.ITER_W(ITER_W)) bus ();

    sqrt_step_controller #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [15:0] datain, operand;
    logic [31:0] square, delta, result;
    logic        le_stuck;

    always @(posedge clock) begin
        if (bus.op_load) operand <= datain;
        if (bus.reg_init) begin
            square <= 32'd1;
            delta  <= 32'd3;
        end else if (bus.step_en) begin
            square <= square + delta;
            delta  <= delta + 32'd2;
        end
        if (bus.res_en) result <= delta / 2 - 1;
    end
    assign bus.le = le_stuck | (square <= {16'd0, operand});

    int checks = 0;
    int failures = 0;

    int o_done, o_steps, o_res, o_nres, o_load;
    int o_iter;
    logic o_err, o_busy;

    function automatic int isqrt(input int a);
        int k = 0;
        while ((k + 1) * (k + 1) <= a) k++;
        return k;
    endfunction

    // Start one op; cycle 1 is the first cycle after the edge that samples start.
    task automatic do_op(input int a, input bit hold, input int pulse_at, input int limit);
        int cyc = 0;
        datain = a[15:0];
        o_done = -1; o_steps = 0; o_res = -1; o_nres = 0; o_load = -1;
        @(negedge clock);
        bus.start = 1'b1;
        while (o_done < 0 && cyc < limit) begin
            @(negedge clock);
            cyc++;
            bus.start = hold || (cyc == pulse_at);
            if (bus.op_load && o_load < 0) o_load = cyc;
            if (bus.step_en) o_steps++;
            if (bus.res_en) begin o_nres++; o_res = cyc; end
            o_iter = int'(bus.iter_count);
            o_err  = bus.err;
            o_busy = bus.busy;
            if (bus.done) o_done = cyc;
        end
    endtask

    task automatic test_reset;
        logic [ITER_W+6:0] outs;
        reset = 1'b0; bus.start = 1'b0; le_stuck = 1'b0;
        repeat (3) @(negedge clock);
        outs = {bus.op_load, bus.reg_init, bus.step_en, bus.res_en, bus.busy, bus.done, bus.err, bus.iter_count};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_op;
        logic [ITER_W+6:0] outs;
        int n = 0;
        datain = 16'd100;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        while (n < 3 && o_load < 1000) begin
            @(negedge clock);
            if (bus.step_en) n++;
            o_load++;
        end
        checks++;
        if (n != 3) begin failures++; $display("FAIL mid_op_steps got=%0d exp=3", n); end
        reset = 1'b0;
        #1;
        outs = {bus.op_load, bus.reg_init, bus.step_en, bus.res_en, bus.busy, bus.done, bus.err, bus.iter_count};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL async_reset_outputs got=%h exp=0", outs); end
        @(negedge clock);
        outs = {bus.op_load, bus.reg_init, bus.step_en, bus.res_en, bus.busy, bus.done, bus.err, bus.iter_count};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL held_reset_outputs got=%h exp=0", outs); end
        reset = 1'b1;
        do_op(100, 1'b0, 0, 2000);
        checks++;
        if (o_done != 25 || result != 32'd10) begin
            failures++; $display("FAIL after_reset_op done=%0d result=%0d exp done=25 result=10", o_done, result);
        end
    endtask

    task automatic test_zero;
        do_op(0, 1'b0, 0, 2000);
        checks++;
        if (o_load != 1 || o_steps != 0 || o_res != 4 || o_done != 5 || o_iter != 0) begin
            failures++;
            $display("FAIL zero_op load=%0d steps=%0d res=%0d done=%0d iter=%0d exp 1/0/4/5/0", o_load, o_steps, o_res, o_done, o_iter);
        end
    endtask

    task automatic test_sixteen;
        do_op(16, 1'b0, 0, 2000);
        checks++;
        if (o_steps != 4 || o_done != 13 || result != 32'd4 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL op16 steps=%0d done=%0d result=%0d err=%b exp 4/13/4/0", o_steps, o_done, result, o_err);
        end
    endtask

    task automatic test_max;
        do_op(65535, 1'b0, 0, 2000);
        checks++;
        if (o_iter != 255 || o_done != 515 || result != 32'd255 || o_err !== 1'b0 || o_nres != 1) begin
            failures++;
            $display("FAIL op65535 iter=%0d done=%0d result=%0d err=%b nres=%0d exp 255/515/255/0/1", o_iter, o_done, result, o_err, o_nres);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            int a = (i % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 300));
            int k = isqrt(a);
            do_op(a, 1'b0, 0, 2000);
            checks++;
            if (o_done != 2 * k + 5 || result != 32'(k) || o_iter != k || o_steps != k || o_nres != 1) begin
                failures++;
                $display("FAIL random_op a=%0d done=%0d result=%0d iter=%0d steps=%0d exp done=%0d k=%0d",
                         a, o_done, result, o_iter, o_steps, 2 * k + 5, k);
            end
        end
    endtask

    task automatic test_busy_start;
        int busy_seen = 0;
        do_op(49, 1'b0, 8, 2000);
        checks++;
        if (o_done != 19 || result != 32'd7) begin
            failures++; $display("FAIL start_during_busy done=%0d result=%0d exp 19/7", o_done, result);
        end
        repeat (4) begin
            @(negedge clock);
            if (bus.busy) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin failures++; $display("FAIL no_queued_op busy_cycles=%0d exp 0", busy_seen); end
    endtask

    task automatic test_back_to_back;
        int c = 1;
        do_op(9, 1'b1, 0, 2000);
        checks++;
        if (o_done != 11) begin failures++; $display("FAIL b2b_first done=%0d exp 11", o_done); end
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap busy=%b exp 0", bus.busy); end
        @(negedge clock);
        checks++;
        if (bus.op_load !== 1'b1) begin failures++; $display("FAIL b2b_reload op_load=%b exp 1", bus.op_load); end
        bus.start = 1'b0;
        while (!bus.done && c < 100) begin
            @(negedge clock);
            c++;
        end
        checks++;
        if (c != 11) begin failures++; $display("FAIL b2b_second done=%0d exp 11", c); end
    endtask

    task automatic test_watchdog;
        le_stuck = 1'b1;
        do_op(5, 1'b0, 0, 700);
`ifdef SQRT_CTRL_WATCHDOG_EN
        checks++;
        if (o_done != 516 || o_err !== 1'b1 || o_nres != 0 || o_steps != MAX_ITER || o_iter != MAX_ITER) begin
            failures++;
            $display("FAIL watchdog_fault done=%0d err=%b nres=%0d steps=%0d iter=%0d exp 516/1/0/256/256",
                     o_done, o_err, o_nres, o_steps, o_iter);
        end
        le_stuck = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL err_sticky err=%b busy=%b exp 1/0", bus.err, bus.busy);
        end
        do_op(4, 1'b0, 0, 2000);
        checks++;
        if (o_err !== 1'b0 || o_done != 9) begin
            failures++; $display("FAIL err_cleared err=%b done=%0d exp 0/9", o_err, o_done);
        end
`else
        checks++;
        if (o_done != -1 || o_iter != MAX_ITER || o_busy !== 1'b1 || o_err !== 1'b0 || o_nres != 0) begin
            failures++;
            $display("FAIL stuck_no_watchdog done=%0d iter=%0d busy=%b err=%b nres=%0d exp -1/256/1/0/0",
                     o_done, o_iter, o_busy, o_err, o_nres);
        end
        le_stuck = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        do_op(4, 1'b0, 0, 2000);
        checks++;
        if (o_done != 9 || result != 32'd2) begin
            failures++; $display("FAIL recover_after_stuck done=%0d result=%0d exp 9/2", o_done, result);
        end
`endif
    endtask

    initial begin
        bus.start = 1'b0;
        le_stuck  = 1'b0;
        datain    = 16'd0;
        o_load    = 0;
        test_reset();
        o_load = 0;
        test_reset_mid_op();
        test_zero();
        test_sixteen();
        test_max();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
